// File: rtl/prbs_hamming_source.sv
// PRBS / pattern bit source that packs DATA_W bits into a Hamming(even) code word
// and hands it to a consumer through a valid/ready holding register.
//
// state   | meaning
// S_IDLE  | generation disabled (en low)
// S_RUN   | advancing one source bit per cycle
// S_STALL | last bit of a word pending while the output register is still full
module prbs_hamming_source #(
    parameter int                LFSR_W    = 7,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 7'b1100000,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 7'b0000001,
    parameter int                DATA_W    = 7,
    parameter int                PAR_W     = 4,
    parameter int                CODE_W    = DATA_W + PAR_W
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_en,
    input  logic [1:0]                  i_mode,
    input  logic [$clog2(CODE_W)-1:0]   i_err_pos,
    input  logic                        i_seed_load,
    output logic [CODE_W-1:0]           o_code,
    output logic                        o_code_valid,
    input  logic                        i_code_ready,
    output logic                        o_send,
    output logic [15:0]                 o_word_cnt
);

    localparam int ERR_W = $clog2(CODE_W);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [LFSR_W-1:0]   r_lfsr;
    logic [DATA_W-1:0]   r_shift;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [1:0]          r_mode;
    logic [CODE_W-1:0]   r_code;
    logic                r_code_valid;
    logic                r_send;
    logic [15:0]         r_word_cnt;

    logic                w_last;
    logic                w_stalled;
    logic                w_advance;
    logic                w_complete;
    logic                w_consume;
    logic [1:0]          w_mode;
    logic                w_src_bit;
    logic                w_feedback;
    logic                w_inject;
    logic [DATA_W-1:0]   w_data;
    logic [CODE_W-1:0]   w_spread;
    logic [CODE_W-1:0]   w_code_raw;
    logic [CODE_W-1:0]   w_err_mask;
    logic [CODE_W-1:0]   w_code_new;
    logic [CODE_W-1:0]   w_cover [PAR_W];

    // ------------------------------------------------------------------
    // Advance / stall qualification
    // ------------------------------------------------------------------
    assign w_last     = (r_bit_cnt == CNT_W'(DATA_W - 1));
    assign w_stalled  = w_last && r_code_valid && !i_code_ready;
    assign w_advance  = i_en && !w_stalled && !i_seed_load;
    assign w_complete = w_advance && w_last;
    assign w_consume  = r_code_valid && i_code_ready;

    // Mode is latched at the first bit of a word; that first bit already uses the new mode.
    assign w_mode     = (r_bit_cnt == '0) ? i_mode : r_mode;
    assign w_feedback = ^(r_lfsr & LFSR_TAPS);

    always_comb begin
        w_src_bit = r_lfsr[LFSR_W-1];
        case (w_mode)
            2'b01:   w_src_bit = 1'b0;
            2'b10:   w_src_bit = ~r_bit_cnt[0];
            default: w_src_bit = r_lfsr[LFSR_W-1];
        endcase
    end

    // Word as it will look once this cycle's bit has shifted in.
    assign w_data = DATA_W'({r_shift, w_src_bit});

    // ------------------------------------------------------------------
    // Hamming even-parity encoder (position p lives in bit p-1)
    // ------------------------------------------------------------------
    for (genvar p = 1; p <= CODE_W; p++) begin : g_pos
        if ((p & (p - 1)) != 0) begin : g_data
            assign w_spread[p-1]   = w_data[p - $clog2(p + 1) - 1];
            assign w_code_raw[p-1] = w_spread[p-1];
        end else begin : g_par
            assign w_spread[p-1]   = 1'b0;
        end
    end

    for (genvar j = 0; j < PAR_W; j++) begin : g_par_grp
        for (genvar q = 1; q <= CODE_W; q++) begin : g_cov
            if (((q >> j) & 1) != 0) begin : g_in
                assign w_cover[j][q-1] = w_spread[q-1];
            end else begin : g_out
                assign w_cover[j][q-1] = 1'b0;
            end
        end
        assign w_code_raw[(1 << j) - 1] = ^w_cover[j];
    end

    // Out-of-range error positions match no bit, so nothing is flipped.
    assign w_inject = (w_mode == 2'b11);
    for (genvar i = 0; i < CODE_W; i++) begin : g_err
        assign w_err_mask[i] = w_inject && (i_err_pos == ERR_W'(i));
    end

    assign w_code_new = w_code_raw ^ w_err_mask;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr       <= LFSR_SEED;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_mode       <= 2'b00;
            r_code       <= '0;
            r_code_valid <= 1'b0;
            r_send       <= 1'b0;
            r_word_cnt   <= '0;
        end else begin
            r_send <= w_complete;

            if (i_seed_load) begin
                r_lfsr    <= LFSR_SEED;
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else begin
                if (r_lfsr == '0) begin
                    r_lfsr <= LFSR_W'(1);
                end else if (w_advance) begin
                    r_lfsr <= {r_lfsr[LFSR_W-2:0], w_feedback};
                end

                if (w_advance) begin
                    r_shift   <= w_data;
                    r_bit_cnt <= w_last ? '0 : r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == '0) begin
                        r_mode <= i_mode;
                    end
                end
            end

            // A completing word refills the register even on a consume edge: no bubble.
            if (w_complete) begin
                r_code       <= w_code_new;
                r_code_valid <= 1'b1;
                r_word_cnt   <= r_word_cnt + 16'd1;
            end else if (w_consume) begin
                r_code_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!i_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_RUN;
                S_RUN:   w_state_nxt = w_stalled ? S_STALL : S_RUN;
                S_STALL: w_state_nxt = i_code_ready ? S_RUN : S_STALL;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign o_code       = r_code;
    assign o_code_valid = r_code_valid;
    assign o_send       = r_send;
    assign o_word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_prbs_hamming_source.sv
// Bench for prbs_hamming_source: queue-based reference model checked every cycle,
// directed scenarios with hand-computed code words, and a narrow instance for the word counter wrap.
module tb_prbs_hamming_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (default parameters)
    logic        rst, en, seed_load, ready;
    logic [1:0]  mode;
    logic [3:0]  err_pos;
    logic [10:0] code;
    logic        valid, send;
    logic [15:0] cnt;

    prbs_hamming_source dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_en         (en),
        .i_mode       (mode),
        .i_err_pos    (err_pos),
        .i_seed_load  (seed_load),
        .o_code       (code),
        .o_code_valid (valid),
        .i_code_ready (ready),
        .o_send       (send),
        .o_word_cnt   (cnt)
    );

    // narrow instance: one bit per word, so 65536 words fit in 65536 cycles
    logic        w_rst, w_en, w_sl, w_rdy;
    logic [1:0]  w_mode;
    logic [1:0]  w_err;
    logic [2:0]  w_code;
    logic        w_valid, w_send;
    logic [15:0] w_cnt;
    bit          wrap_done = 1'b0;

    prbs_hamming_source #(.DATA_W(1), .PAR_W(2)) dut_wrap (
        .i_clk        (clk),
        .i_reset      (w_rst),
        .i_en         (w_en),
        .i_mode       (w_mode),
        .i_err_pos    (w_err),
        .i_seed_load  (w_sl),
        .o_code       (w_code),
        .o_code_valid (w_valid),
        .i_code_ready (w_rdy),
        .o_send       (w_send),
        .o_word_cnt   (w_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: bits collected in a queue, encoding via syndrome
    // ------------------------------------------------------------------
    function automatic logic [10:0] model_encode(input logic [6:0] d);
        int          dpos [7];
        int          syn;
        logic [10:0] c;
        dpos = '{3, 5, 6, 7, 9, 10, 11};
        syn  = 0;
        c    = '0;
        for (int k = 0; k < 7; k++) begin
            if (((d >> k) & 7'd1) != 0) begin
                c   = c | (11'd1 << (dpos[k] - 1));
                syn = syn ^ dpos[k];
            end
        end
        // parity bits chosen so the XOR of all set positions is zero
        for (int j = 0; j < 4; j++) begin
            if (((syn >> j) & 1) != 0) c = c | (11'd1 << ((1 << j) - 1));
        end
        return c;
    endfunction

    int          m_lfsr;
    bit          m_bits[$];
    logic [1:0]  m_wmode;
    logic [10:0] m_code;
    bit          m_valid, m_send;
    int          m_cnt;
    bit          m_live = 1'b0;

    task automatic model_step();
        bit         stalled, consume, ld, b;
        logic [6:0] d;
        if (rst) begin
            m_lfsr  = 1;
            m_bits.delete();
            m_wmode = 2'b00;
            m_code  = '0;
            m_valid = 1'b0;
            m_send  = 1'b0;
            m_cnt   = 0;
            m_live  = 1'b1;
        end else if (m_live) begin
            stalled = (m_bits.size() == 6) && m_valid && !ready;
            consume = m_valid && ready;
            ld      = 1'b0;
            if (seed_load) begin
                m_lfsr = 1;
                m_bits.delete();
            end else if (en && !stalled) begin
                if (m_bits.size() == 0) m_wmode = mode;
                case (m_wmode)
                    2'b01:   b = 1'b0;
                    2'b10:   b = (m_bits.size() % 2 == 0);
                    default: b = ((m_lfsr >> 6) & 1) != 0;
                endcase
                // x^7 + x^6 + 1
                m_lfsr = ((m_lfsr << 1) & 'h7F) | (((m_lfsr >> 6) ^ (m_lfsr >> 5)) & 1);
                m_bits.push_back(b);
                if (m_bits.size() == 7) begin
                    d = '0;
                    for (int k = 0; k < 7; k++) if (m_bits[k]) d = d | (7'd1 << (6 - k));
                    m_code = model_encode(d);
                    if (m_wmode == 2'b11 && err_pos < 11) m_code = m_code ^ (11'd1 << err_pos);
                    ld = 1'b1;
                    m_bits.delete();
                end
            end
            if (ld) m_valid = 1'b1;
            else if (consume) m_valid = 1'b0;
            m_send = ld;
            if (ld) m_cnt = (m_cnt + 1) % 65536;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            check("m_code",  code,  m_code);
            check("m_valid", valid, m_valid);
            check("m_send",  send,  m_send);
            check("m_cnt",   cnt,   m_cnt[15:0]);
        end
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    task automatic wait_send(input int max, output int n);
        n = 0;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (send === 1'b1) begin
                n = i;
                break;
            end
        end
        check("send_seen", (n != 0), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int n;

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; err_pos = 4'd15; seed_load = 1'b0; ready = 1'b1;
        tick();
        tick();
        check("rst_code",  code,  11'h000);
        check("rst_valid", valid, 1'b0);
        check("rst_send",  send,  1'b0);
        check("rst_cnt",   cnt,   16'd0);

        check("pin_enc_01", model_encode(7'h01), 11'h007);
        check("pin_enc_03", model_encode(7'h03), 11'h01E);
        check("pin_enc_55", model_encode(7'h55), 11'h52F);
        check("pin_enc_7f", model_encode(7'h7F), 11'h7FF);

        // mode 00: first two PRBS words from the seed
        en = 1'b1; rst = 1'b0;
        wait_send(20, n);
        check("prbs_latency", n, 7);
        check("prbs_word1", code, 11'h007);
        check("prbs_cnt1", cnt, 16'd1);
        tick();
        check("send_pulse", send, 1'b0);
        wait_send(20, n);
        check("prbs_word2", code, 11'h01E);
        check("prbs_cnt2", cnt, 16'd2);

        // mode 01: all-zero words every 7 advances
        mode = 2'b01;
        do_reset();
        wait_send(20, n);
        check("zero_word1", code, 11'h000);
        wait_send(20, n);
        check("zero_spacing", n, 7);
        check("zero_word2", code, 11'h000);

        // mode 10: alternating pattern
        mode = 2'b10;
        do_reset();
        wait_send(20, n);
        check("alt_word", code, 11'h52F);

        // mode 11: error injection and its boundaries
        mode = 2'b11; err_pos = 4'd0;
        do_reset();
        wait_send(20, n);
        check("err0_word", code, 11'h006);
        err_pos = 4'd10;
        do_reset();
        wait_send(20, n);
        check("err10_word", code, 11'h407);
        err_pos = 4'd11;
        do_reset();
        wait_send(20, n);
        check("err11_word", code, 11'h007);
        err_pos = 4'd15;
        do_reset();
        wait_send(20, n);
        check("err15_word", code, 11'h007);

        // back-pressure: 20 cycles with code_ready low
        mode = 2'b00; ready = 1'b0;
        do_reset();
        wait_send(20, n);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("stall_code",  code,  11'h007);
            check("stall_valid", valid, 1'b1);
        end
        ready = 1'b1;
        wait_send(20, n);
        check("release_latency", n, 1);
        check("release_word", code, 11'h01E);
        check("release_valid", valid, 1'b1);
        check("release_cnt", cnt, 16'd2);

        // mode change mid-word applies at the next word
        mode = 2'b01;
        do_reset();
        tick(); tick(); tick();
        mode = 2'b00;
        wait_send(20, n);
        check("modechg_word1", code, 11'h000);
        wait_send(20, n);
        check("modechg_word2", code, 11'h01E);

        // seed_load mid-word with a pending code
        ready = 1'b0;
        do_reset();
        wait_send(20, n);
        tick(); tick();
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check("seed_keep_valid", valid, 1'b1);
        check("seed_keep_code", code, 11'h007);
        ready = 1'b1;
        wait_send(20, n);
        check("seed_latency", n, 7);
        check("seed_word", code, 11'h007);
        check("seed_cnt", cnt, 16'd2);

        // reset mid-word with en held high
        do_reset();
        wait_send(20, n);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_code",  code,  11'h000);
        check("midrst_valid", valid, 1'b0);
        check("midrst_send",  send,  1'b0);
        check("midrst_cnt",   cnt,   16'd0);
        rst = 1'b0;
        wait_send(20, n);
        check("midrst_latency", n, 7);
        check("midrst_word", code, 11'h007);

        // PRBS period: 127 words = 889 bits = 7 full periods of 127
        do_reset();
        for (int w = 1; w <= 127; w++) wait_send(20, n);
        check("model_period", m_lfsr, 1);
        wait_send(20, n);
        check("period_word128", code, 11'h007);
        check("period_cnt", cnt, 16'd128);
        wait_send(20, n);
        check("period_word129", code, 11'h01E);

        en = 1'b0;
        n = 0;
        for (int i = 0; i < 80000; i++) begin
            if (wrap_done) begin
                n = 1;
                break;
            end
            tick();
        end
        check("wrap_finished", n, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // word counter wrap on the one-bit-per-word instance
    initial begin
        w_rst = 1'b1; w_en = 1'b1; w_mode = 2'b01; w_err = 2'd3; w_sl = 1'b0; w_rdy = 1'b1;
        tick();
        tick();
        w_rst = 1'b0;
        check("wrap_rst_cnt", w_cnt, 16'd0);
        repeat (65535) tick();
        check("wrap_ffff", w_cnt, 16'hFFFF);
        check("wrap_send", w_send, 1'b1);
        check("wrap_valid", w_valid, 1'b1);
        check("wrap_code", w_code, 3'b000);
        tick();
        check("wrap_zero", w_cnt, 16'd0);
        tick();
        check("wrap_one", w_cnt, 16'd1);
        wrap_done = 1'b1;
    end

endmodule

// File: doc/prbs_hamming_source.md
PRBS_HAMMING_SOURCE -- requirements
Module: prbs_hamming_source

Interface
REQ-001 The block SHALL have these parameters:
- LFSR_W, 7, LFSR length.
- LFSR_TAPS, 7'b1100000, feedback tap mask (x^7+x^6+1).
- LFSR_SEED, 7'b0000001, reset/load seed, nonzero.
- DATA_W, 7, information bits per word.
- PAR_W, 4, parity bits; DATA_W <= 2^PAR_W-PAR_W-1.
- CODE_W, DATA_W+PAR_W, code word width.
REQ-002 The block SHALL have these ports:
- clk  in  1  the single clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  generation enable.
- mode  in  2  00 PRBS, 01 all-zero, 10 alternating, 11 PRBS with single-bit error injection.
- err_pos  in  clog2(CODE_W)  code bit flipped in mode 11.
- seed_load  in  1  reload LFSR with LFSR_SEED.
- code  out  CODE_W  Hamming code word.
- code_valid  out  1  code holds an unconsumed word.
- code_ready  in  1  consumer accepts code.
- send  out  1  one-cycle pulse when a new word is loaded.
- word_cnt  out  16  words loaded since reset.

Function
REQ-003 The LFSR SHALL be Fibonacci: out bit = lfsr[LFSR_W-1], next = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}, advancing only on an advance cycle.
REQ-004 An advance cycle SHALL be en=1 and not stalled, where stalled = (bit_cnt==DATA_W-1) && code_valid && !code_ready.
REQ-005 The source bit SHALL be: mode 00/11 LFSR out bit; 01 constant 0; 10 alternating 1,0,1,... starting with 1 at each word's MSB.
REQ-006 On each advance the shifter SHALL take the source bit in at the LSB; the first bit of a word ends in data[DATA_W-1].
REQ-007 bit_cnt SHALL count advances 0..DATA_W-1 and wrap to 0 on the DATA_W-th advance (word completion).
REQ-008 mode SHALL be sampled only when bit_cnt==0 and held for the whole word; mid-word changes SHALL take effect at the next word.
REQ-009 Encoding SHALL be Hamming even parity: code[i] is position i+1, parity at power-of-two positions, data bits at the remaining positions in ascending order (data[0] at position 3), parity p(2^j) = XOR of all positions whose index has bit j set.
REQ-010 In mode 11, code bit err_pos SHALL be inverted at load; err_pos >= CODE_W SHALL inject no error.
REQ-011 On word completion the encoded word SHALL be registered into code on the same edge, with code_valid=1 and send=1 for one cycle; latency is one clock from the final advance edge.
REQ-012 code/code_valid SHALL hold stable while code_valid && !code_ready; the word is consumed on an edge where both are 1.
REQ-013 Simultaneous consume and completion SHALL load the new word and keep code_valid=1 with no bubble.
REQ-014 The FSM SHALL have three states:
- IDLE (en=0), RUN (advancing), STALL (last bit pending, output full).
- Transitions: IDLE->RUN on en; RUN->STALL when stalled; STALL->RUN on code_ready; any->IDLE when en=0.
- In STALL neither the LFSR nor the shifter moves, so no bit is lost.
REQ-015 seed_load SHALL set lfsr=LFSR_SEED and bit_cnt=0, discarding the partial word, without affecting a pending code; it overrides an advance in the same cycle.
REQ-016 If the LFSR state is ever all-zero it SHALL load 1 on the next edge (lock-up guard).
REQ-017 word_cnt SHALL increment on each load and wrap 16'hFFFF->0.

Reset
REQ-018 On reset=1 at a clk edge the block SHALL set lfsr=LFSR_SEED, bit_cnt=0, shifter=0, code=0, code_valid=0, send=0, word_cnt=0, and state=IDLE; reset overrides all other inputs, including mid-word.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Defaults, mode 00, en=1, code_ready=1 after reset -> first word data 7'h01, code=11'h007, send pulse one cycle, word_cnt=1.
- Mode 01 -> code=11'h000 every 7 advances.
- Mode 11, err_pos=0 -> first code=11'h006; err_pos=15 -> 11'h007.
- code_ready=0 for 20 cycles -> code_valid held, code stable, state STALL, LFSR frozen; releasing code_ready -> next word is the same as an unstalled run.
- Mode change mid-word, seed_load mid-word, and reset mid-word -> change applied at the next word, partial word discarded, all outputs return to reset values.
- 65536 words -> word_cnt wraps to 0; PRBS period 127 verified.
